cms_ctrl_write_arbiter: RTL and testbench



---
 rtl/cms_ctrl_write_arbiter_pkg.sv | 16 +
 rtl/cms_ctrl_write_arbiter_rr_arbiter2.sv | 19 +
 rtl/cms_ctrl_write_arbiter.sv | 124 ++++++++++++
 tb/tb_cms_ctrl_write_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cms_ctrl_write_arbiter_pkg.sv
// Shared types and constants for the monitoring-system control-write arbiter.
// Holds the sequencer state encoding, default port widths and the phase-timer width.
package cms_ctrl_write_arbiter_pkg;

  localparam int unsigned CtrlAddrWidthDef = 8;
  localparam int unsigned CtrlDataWidthDef = 64;
  localparam int unsigned TimerWidth       = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StPulse,
    StGap
  } arb_state_e;

endpackage

// File: rtl/cms_ctrl_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is chosen.
// Purely combinational; the caller owns the last-grant register.
module cms_ctrl_write_arbiter_rr_arbiter2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = i_last_grant ? 2'b01 : 2'b10;
    end
  end

  assign o_grant_idx = o_grant[1];

endmodule

// File: rtl/cms_ctrl_write_arbiter.sv
// Shares the monitoring system's single control-write port between host and on-chip requesters.
// Each accepted write runs setup -> enable pulse -> low gap so the sink sees one rising edge.
module cms_ctrl_write_arbiter
  import cms_ctrl_write_arbiter_pkg::*;
#(
  parameter int unsigned CTRL_ADDR_WIDTH = CtrlAddrWidthDef,
  parameter int unsigned CTRL_DATA_WIDTH = CtrlDataWidthDef,
  parameter int unsigned PULSE_CYCLES    = 1,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req0_valid,
  output logic                       o_req0_ready,
  input  logic [CTRL_ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] i_req0_wdata,
  input  logic                       i_req1_valid,
  output logic                       o_req1_ready,
  input  logic [CTRL_ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] i_req1_wdata,
  output logic [CTRL_ADDR_WIDTH-1:0] o_ctrl_addr,
  output logic [CTRL_DATA_WIDTH-1:0] o_ctrl_wdata,
  output logic                       o_ctrl_write_enable,
  output logic                       o_busy,
  output logic                       o_last_grant,
  output logic [31:0]                o_write_count
);

  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15) begin : g_bad_pulse
    $fatal(1, "PULSE_CYCLES must be in 1..15");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $fatal(1, "GAP_CYCLES must be in 1..15");
  end

  localparam logic [TimerWidth-1:0] PulseLoad = TimerWidth'(PULSE_CYCLES - 1);
  localparam logic [TimerWidth-1:0] GapLoad   = TimerWidth'(GAP_CYCLES - 1);

  arb_state_e                 r_state;
  logic [TimerWidth-1:0]      r_cnt;
  logic                       r_last_grant;
  logic                       r_busy;
  logic                       r_we;
  logic [CTRL_ADDR_WIDTH-1:0] r_addr;
  logic [CTRL_DATA_WIDTH-1:0] r_wdata;
  logic [31:0]                r_write_count;

  logic [1:0] w_grant;
  logic       w_grant_idx;
  logic       w_idle;
  logic       w_accept;
  logic       w_done;

  cms_ctrl_write_arbiter_rr_arbiter2 u_rr_arbiter2 (
    .i_valid      ({i_req1_valid, i_req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  assign w_idle       = (r_state == StIdle);
  assign o_req0_ready = w_idle & w_grant[0];
  assign o_req1_ready = w_idle & w_grant[1];
  // A grant only exists for a valid requester, so this is valid && ready.
  assign w_accept     = w_idle & (|w_grant);
  assign w_done       = (r_state == StGap) && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_last_grant  <= 1'b1;
      r_busy        <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_write_count <= '0;
    end else begin
      r_write_count <= r_write_count + 32'(w_done);
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state      <= StSetup;
            r_busy       <= 1'b1;
            r_last_grant <= w_grant_idx;
            r_addr       <= w_grant_idx ? i_req1_addr : i_req0_addr;
            r_wdata      <= w_grant_idx ? i_req1_wdata : i_req0_wdata;
          end
        end
        StSetup: begin
          r_state <= StPulse;
          r_we    <= 1'b1;
          r_cnt   <= PulseLoad;
        end
        StPulse: begin
          if (r_cnt == '0) begin
            r_state <= StGap;
            r_we    <= 1'b0;
            r_cnt   <= GapLoad;
          end else begin
            r_cnt <= r_cnt - TimerWidth'(1);
          end
        end
        StGap: begin
          if (r_cnt == '0) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - TimerWidth'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ctrl_addr         = r_addr;
  assign o_ctrl_wdata        = r_wdata;
  assign o_ctrl_write_enable = r_we;
  assign o_busy              = r_busy;
  assign o_last_grant        = r_last_grant;
  assign o_write_count       = r_write_count;

endmodule

// File: tb/tb_cms_ctrl_write_arbiter.sv
// Bench for the control-write arbiter: directed scenarios plus a randomized run against a
// transaction-level model (arbitration rule and per-write timing computed arithmetically).
module tb_cms_ctrl_write_arbiter;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int PA = 1;
  localparam int GA = 1;
  localparam int PB = 3;
  localparam int GB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, rst_b;
  logic          a_v0, a_v1, a_r0, a_r1, a_we, a_busy, a_last;
  logic [AW-1:0] a_addr0, a_addr1, a_caddr;
  logic [DW-1:0] a_wd0, a_wd1, a_cwd;
  logic [31:0]   a_cnt;
  logic          b_v0, b_v1, b_r0, b_r1, b_we, b_busy, b_last;
  logic [AW-1:0] b_addr0, b_addr1, b_caddr;
  logic [DW-1:0] b_wd0, b_wd1, b_cwd;
  logic [31:0]   b_cnt;

  int checks   = 0;
  int failures = 0;

  cms_ctrl_write_arbiter #(
    .CTRL_ADDR_WIDTH (AW),
    .CTRL_DATA_WIDTH (DW),
    .PULSE_CYCLES    (PA),
    .GAP_CYCLES      (GA)
  ) dut_a (
    .i_clk (clk), .i_rst (rst_a),
    .i_req0_valid (a_v0), .o_req0_ready (a_r0), .i_req0_addr (a_addr0), .i_req0_wdata (a_wd0),
    .i_req1_valid (a_v1), .o_req1_ready (a_r1), .i_req1_addr (a_addr1), .i_req1_wdata (a_wd1),
    .o_ctrl_addr (a_caddr), .o_ctrl_wdata (a_cwd), .o_ctrl_write_enable (a_we),
    .o_busy (a_busy), .o_last_grant (a_last), .o_write_count (a_cnt)
  );

  cms_ctrl_write_arbiter #(
    .CTRL_ADDR_WIDTH (AW),
    .CTRL_DATA_WIDTH (DW),
    .PULSE_CYCLES    (PB),
    .GAP_CYCLES      (GB)
  ) dut_b (
    .i_clk (clk), .i_rst (rst_b),
    .i_req0_valid (b_v0), .o_req0_ready (b_r0), .i_req0_addr (b_addr0), .i_req0_wdata (b_wd0),
    .i_req1_valid (b_v1), .o_req1_ready (b_r1), .i_req1_addr (b_addr1), .i_req1_wdata (b_wd1),
    .o_ctrl_addr (b_caddr), .o_ctrl_wdata (b_cwd), .o_ctrl_write_enable (b_we),
    .o_busy (b_busy), .o_last_grant (b_last), .o_write_count (b_cnt)
  );

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset_a();
    a_v0 = 1'b0; a_v1 = 1'b0; rst_a = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    do_reset_a();
    checks++;
    if ({a_we, a_busy, a_last, a_r0, a_r1} !== 5'b00100) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00100", {a_we, a_busy, a_last, a_r0, a_r1});
    end
    checks++;
    if ({a_caddr, a_cwd, a_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_regs: got addr=%h wdata=%h cnt=%h expected zeros", a_caddr, a_cwd, a_cnt);
    end
    a_v0 = 1'b1; a_v1 = 1'b1; #1;
    checks++;
    if ({a_r0, a_r1} !== 2'b10) begin
      failures++;
      $display("FAIL reset_tie_ready: got %b expected 10", {a_r0, a_r1});
    end
    a_v0 = 1'b0; a_v1 = 1'b0;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_accept_busy: got %b expected 0", a_busy);
    end
  endtask

  task automatic test_single_write();
    logic e_we, e_busy;
    logic [31:0] e_cnt;
    do_reset_a();
    a_addr0 = 8'h12; a_wd0 = 64'hDEADBEEF_00000001; a_v0 = 1'b1; #1;
    checks++;
    if ({a_r0, a_r1} !== 2'b10) begin
      failures++;
      $display("FAIL single_ready: got %b expected 10", {a_r0, a_r1});
    end
    @(negedge clk);
    a_v0 = 1'b0;
    for (int k = 1; k <= 2 + PA + GA; k++) begin
      e_we   = (k >= 2) && (k <= 1 + PA);
      e_busy = (k <= 1 + PA + GA);
      e_cnt  = (k == 2 + PA + GA) ? 32'd1 : 32'd0;
      checks++;
      if ({a_busy, a_we, a_r0} !== {e_busy, e_we, 1'b0}) begin
        failures++;
        $display("FAIL single_flags[k=%0d]: got busy/we/rdy=%b expected %b", k,
                 {a_busy, a_we, a_r0}, {e_busy, e_we, 1'b0});
      end
      checks++;
      if ({a_caddr, a_cwd} !== {8'h12, 64'hDEADBEEF_00000001}) begin
        failures++;
        $display("FAIL single_addr_data[k=%0d]: got %h/%h expected 12/deadbeef00000001", k,
                 a_caddr, a_cwd);
      end
      checks++;
      if (a_cnt !== e_cnt) begin
        failures++;
        $display("FAIL single_count[k=%0d]: got %0d expected %0d", k, a_cnt, e_cnt);
      end
      if (k < 2 + PA + GA) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int   order[$];
    int   rises[$];
    logic prev_we;
    do_reset_a();
    a_addr0 = 8'h01; a_addr1 = 8'h02;
    a_wd0 = 64'h1111_0000_0000_0001; a_wd1 = 64'h2222_0000_0000_0002;
    a_v0 = 1'b1; a_v1 = 1'b1; prev_we = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (order.size() >= 4) begin
        a_v0 = 1'b0; a_v1 = 1'b0;
      end
      #1;
      checks++;
      if ((a_r0 & a_r1) !== 1'b0) begin
        failures++;
        $display("FAIL b2b_one_ready[t=%0d]: got both ready, expected at most one", t);
      end
      checks++;
      if (((a_r0 | a_r1) & a_busy) !== 1'b0) begin
        failures++;
        $display("FAIL b2b_ready_busy[t=%0d]: got ready while busy, expected none", t);
      end
      if (a_r0) order.push_back(0);
      if (a_r1) order.push_back(1);
      if (a_we && !prev_we) rises.push_back(t);
      prev_we = a_we;
      @(negedge clk);
    end
    checks++;
    if (order.size() != 4) begin
      failures++;
      $display("FAIL b2b_grants: got %0d expected 4", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] != (i % 2)) begin
        failures++;
        $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, order[i], i % 2);
      end
    end
    checks++;
    if (rises.size() != 4) begin
      failures++;
      $display("FAIL b2b_rises: got %0d expected 4", rises.size());
    end
    for (int i = 1; i < rises.size(); i++) begin
      checks++;
      if (rises[i] - rises[i-1] != 2 + PA + GA) begin
        failures++;
        $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, rises[i] - rises[i-1],
                 2 + PA + GA);
      end
    end
    checks++;
    if ({a_busy, a_cnt} !== {1'b0, 32'd4}) begin
      failures++;
      $display("FAIL b2b_count: got busy=%b cnt=%0d expected busy=0 cnt=4", a_busy, a_cnt);
    end
  endtask

  task automatic test_pulse_gap_b();
    int   busy_n, we_n;
    logic e_we, e_busy;
    b_v0 = 1'b0; b_v1 = 1'b0; rst_b = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_b = 1'b0;
    b_addr1 = 8'hA7; b_wd1 = 64'h0123_4567_89AB_CDEF; b_v1 = 1'b1; #1;
    checks++;
    if ({b_r0, b_r1} !== 2'b01) begin
      failures++;
      $display("FAIL pg_ready: got %b expected 01", {b_r0, b_r1});
    end
    @(negedge clk);
    b_v1 = 1'b0; busy_n = 0; we_n = 0;
    for (int k = 1; k <= 2 + PB + GB; k++) begin
      e_we   = (k >= 2) && (k <= 1 + PB);
      e_busy = (k <= 1 + PB + GB);
      checks++;
      if ({b_busy, b_we} !== {e_busy, e_we}) begin
        failures++;
        $display("FAIL pg_flags[k=%0d]: got busy/we=%b expected %b", k, {b_busy, b_we},
                 {e_busy, e_we});
      end
      checks++;
      if ({b_caddr, b_cwd} !== {8'hA7, 64'h0123_4567_89AB_CDEF}) begin
        failures++;
        $display("FAIL pg_addr_data[k=%0d]: got %h/%h expected a7/0123456789abcdef", k,
                 b_caddr, b_cwd);
      end
      if (b_busy) busy_n++;
      if (b_we) we_n++;
      if (k < 2 + PB + GB) @(negedge clk);
    end
    checks++;
    if (busy_n != 1 + PB + GB) begin
      failures++;
      $display("FAIL pg_busy_cycles: got %0d expected %0d", busy_n, 1 + PB + GB);
    end
    checks++;
    if (we_n != PB) begin
      failures++;
      $display("FAIL pg_we_cycles: got %0d expected %0d", we_n, PB);
    end
    checks++;
    if ({b_cnt, b_last} !== {32'd1, 1'b1}) begin
      failures++;
      $display("FAIL pg_count_last: got cnt=%0d last=%b expected cnt=1 last=1", b_cnt, b_last);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    do_reset_a();
    a_addr0 = 8'h5A; a_wd0 = 64'h5A5A_5A5A_5A5A_5A5A; a_v0 = 1'b1;
    @(negedge clk);
    a_v0 = 1'b0;
    @(negedge clk);
    checks++;
    if (a_we !== 1'b1) begin
      failures++;
      $display("FAIL mid_pulse_we: got %b expected 1", a_we);
    end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    checks++;
    if ({a_we, a_busy, a_last} !== 3'b001) begin
      failures++;
      $display("FAIL mid_rst_flags: got we/busy/last=%b expected 001", {a_we, a_busy, a_last});
    end
    checks++;
    if ({a_caddr, a_cwd, a_cnt} !== '0) begin
      failures++;
      $display("FAIL mid_rst_regs: got addr=%h wdata=%h cnt=%0d expected zeros", a_caddr, a_cwd,
               a_cnt);
    end
    addr = 8'($urandom); wd = {$urandom, $urandom};
    a_addr1 = addr; a_wd1 = wd; a_v1 = 1'b1; #1;
    checks++;
    if (a_r1 !== 1'b1) begin
      failures++;
      $display("FAIL mid_req1_ready: got %b expected 1", a_r1);
    end
    @(negedge clk);
    a_v1 = 1'b0;
    repeat (1 + PA + GA) @(negedge clk);
    checks++;
    if ({a_busy, a_last, a_cnt, a_caddr, a_cwd} !== {1'b0, 1'b1, 32'd1, addr, wd}) begin
      failures++;
      $display("FAIL mid_after_write: got busy=%b last=%b cnt=%0d addr=%h expected 0/1/1/%h",
               a_busy, a_last, a_cnt, a_caddr, addr);
    end
  endtask

  task automatic test_late_req();
    do_reset_a();
    a_addr0 = 8'h33; a_wd0 = 64'h3; a_v0 = 1'b1;
    @(negedge clk);
    a_v0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_addr1 = 8'h44; a_wd1 = 64'h4; a_v1 = 1'b1; #1;
    checks++;
    if ({a_busy, a_r1} !== 2'b10) begin
      failures++;
      $display("FAIL late_gap_ready: got busy/rdy1=%b expected 10", {a_busy, a_r1});
    end
    @(negedge clk);
    checks++;
    if ({a_busy, a_r0, a_r1} !== 3'b001) begin
      failures++;
      $display("FAIL late_idle_ready: got busy/rdy0/rdy1=%b expected 001", {a_busy, a_r0, a_r1});
    end
    @(negedge clk);
    checks++;
    if ({a_busy, a_r1, a_caddr} !== {1'b1, 1'b0, 8'h44}) begin
      failures++;
      $display("FAIL late_setup: got busy=%b rdy1=%b addr=%h expected 1/0/44", a_busy, a_r1,
               a_caddr);
    end
    a_v1 = 1'b0;
    repeat (1 + PA + GA) @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset_a();
    force dut_a.r_write_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_a.r_write_count;
    checks++;
    if (a_cnt !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_preload: got %h expected ffffffff", a_cnt);
    end
    a_addr0 = 8'h77; a_wd0 = 64'h7; a_v0 = 1'b1;
    @(negedge clk);
    a_v0 = 1'b0;
    repeat (1 + PA + GA) @(negedge clk);
    checks++;
    if ({a_busy, a_cnt} !== {1'b0, 32'h0000_0000}) begin
      failures++;
      $display("FAIL wrap_count: got busy=%b cnt=%h expected busy=0 cnt=00000000", a_busy, a_cnt);
    end
  endtask

  task automatic test_random();
    bit            p0, p1, inf;
    int            acc, k;
    logic          m_last, e_busy, e_we, e_r0, e_r1;
    logic [31:0]   m_cnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    do_reset_a();
    p0 = 1'b0; p1 = 1'b0; inf = 1'b0; acc = 0;
    m_last = 1'b1; m_cnt = '0; m_addr = '0; m_wd = '0;
    for (int t = 0; t < 400; t++) begin
      k = t - acc;
      if (inf && k == 2 + PA + GA) begin
        inf = 1'b0;
        m_cnt++;
      end
      e_busy = inf;
      e_we   = inf && (k >= 2) && (k <= 1 + PA);
      checks++;
      if ({a_busy, a_we, a_last} !== {e_busy, e_we, m_last}) begin
        failures++;
        $display("FAIL rand_flags[t=%0d]: got busy/we/last=%b expected %b", t,
                 {a_busy, a_we, a_last}, {e_busy, e_we, m_last});
      end
      checks++;
      if ({a_caddr, a_cwd, a_cnt} !== {m_addr, m_wd, m_cnt}) begin
        failures++;
        $display("FAIL rand_regs[t=%0d]: got %h/%h/%0d expected %h/%h/%0d", t, a_caddr, a_cwd,
                 a_cnt, m_addr, m_wd, m_cnt);
      end
      if (!p0 && $urandom_range(0, 3) == 0) begin
        p0 = 1'b1; a_addr0 = 8'($urandom); a_wd0 = {$urandom, $urandom};
      end
      if (!p1 && $urandom_range(0, 3) == 0) begin
        p1 = 1'b1; a_addr1 = 8'($urandom); a_wd1 = {$urandom, $urandom};
      end
      a_v0 = p0; a_v1 = p1; #1;
      e_r0 = !inf && p0 && (!p1 || m_last);
      e_r1 = !inf && p1 && (!p0 || !m_last);
      checks++;
      if ({a_r0, a_r1} !== {e_r0, e_r1}) begin
        failures++;
        $display("FAIL rand_ready[t=%0d]: got %b expected %b", t, {a_r0, a_r1}, {e_r0, e_r1});
      end
      if (e_r0 || e_r1) begin
        inf = 1'b1; acc = t; m_last = e_r1;
        m_addr = e_r1 ? a_addr1 : a_addr0;
        m_wd   = e_r1 ? a_wd1 : a_wd0;
        if (e_r1) p1 = 1'b0;
        else p0 = 1'b0;
      end
      @(negedge clk);
    end
    a_v0 = 1'b0; a_v1 = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_v0 = 1'b0; a_v1 = 1'b0; a_addr0 = '0; a_addr1 = '0; a_wd0 = '0; a_wd1 = '0;
    b_v0 = 1'b0; b_v1 = 1'b0; b_addr0 = '0; b_addr1 = '0; b_wd0 = '0; b_wd1 = '0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_pulse_gap_b();
    test_reset_mid();
    test_late_req();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
